// File: rtl/ak_add_pkg.sv
// ak_add_pkg: shared mode encoding, stage-count derivation and split check for the pipelined adder
package ak_add_pkg;

    typedef enum logic {ADD = 1'b0, SUB = 1'b1} mode_e;

    function automatic int stages(input int width, input int seg);
        return width / seg;
    endfunction

    function automatic bit split_ok(input int width, input int seg);
        return seg > 0 && width >= seg && width % seg == 0;
    endfunction

endpackage

// File: rtl/ak_fa.sv
// ak_fa: 1-bit full-adder cell
module ak_fa (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/ak_slice_add.sv
// ak_slice_add: combinational SEG-bit ripple-carry slice exporting carry into and out of its MSB
module ak_slice_add #(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] a_i,
    input  logic [SEG-1:0] b_i,
    input  logic           c_i,
    output logic [SEG-1:0] s_o,
    output logic           c_o,
    output logic           cm_o
);

    logic [SEG:0] c;

    assign c[0] = c_i;

    for (genvar i = 0; i < SEG; i++) begin : g_fa
        ak_fa u_fa (
            .a_i(a_i[i]),
            .b_i(b_i[i]),
            .c_i(c[i]),
            .s_o(s_o[i]),
            .c_o(c[i+1])
        );
    end

    assign c_o  = c[SEG];
    assign cm_o = c[SEG-1];

endmodule

// File: rtl/ak_pipe_addsub.sv
// ak_pipe_addsub: pipelined add/subtract, one SEG-bit slice resolved per stage, valid/ready both sides
module ak_pipe_addsub
    import ak_add_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = stages(WIDTH, SEG);

    if (!split_ok(WIDTH, SEG)) begin : g_bad_split
        $error("ak_pipe_addsub: WIDTH must be a non-zero multiple of SEG");
    end

    logic                        en;
    logic                        is_sub;
    logic                        unused_ops;
    logic [STAGES-1:0]           v_q, v_d, c_q, c_d, o_q, o_d;
    logic [STAGES-1:0][WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;

    // The whole pipe advances together; a stalled output freezes every stage, bubbles included.
    assign en       = !v_q[STAGES-1] || out_ready;
    assign in_ready = rst_n && en;
    assign is_sub   = mode_e'(sub) == SUB;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] ai, bi, si, sn;
        logic [SEG-1:0]   ss;
        logic             ci, vi, co, cm;
        if (k == 0) begin : g_head
            assign ai = a;
            assign bi = is_sub ? ~b : b;
            assign ci = is_sub ? ~cin : cin;
            assign si = '0;
            assign vi = in_valid;
        end else begin : g_tail
            assign ai = a_q[k-1];
            assign bi = b_q[k-1];
            assign ci = c_q[k-1];
            assign si = s_q[k-1];
            assign vi = v_q[k-1];
        end
        ak_slice_add #(.SEG(SEG)) u_slice (
            .a_i (ai[k*SEG +: SEG]),
            .b_i (bi[k*SEG +: SEG]),
            .c_i (ci),
            .s_o (ss),
            .c_o (co),
            .cm_o(cm)
        );
        // Merge this stage's freshly resolved slice into the partial sum travelling with the bundle.
        always_comb begin
            sn = si;
            sn[k*SEG +: SEG] = ss;
        end
        assign a_d[k] = ai;
        assign b_d[k] = bi;
        assign s_d[k] = sn;
        assign c_d[k] = co;
        assign o_d[k] = cm ^ co;
        assign v_d[k] = vi;
    end

    // Stage registers: valids always shift on advance, data only follows a valid bundle so bubbles keep old outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q <= '0;
            a_q <= '0;
            b_q <= '0;
            s_q <= '0;
            c_q <= '0;
            o_q <= '0;
        end else if (en) begin
            v_q <= v_d;
            for (int i = 0; i < STAGES; i++) begin
                if (v_d[i]) begin
                    a_q[i] <= a_d[i];
                    b_q[i] <= b_d[i];
                    s_q[i] <= s_d[i];
                    c_q[i] <= c_d[i];
                    o_q[i] <= o_d[i];
                end
            end
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign ovf       = o_q[STAGES-1];

    // Consumed operand slices and early-stage overflow flags are carried but never read.
    assign unused_ops = ^{a_q, b_q, o_q};

endmodule

// File: tb/tb_ak_pipe_addsub.sv
// tb_ak_pipe_addsub: randomized and directed check of ak_pipe_addsub against an arithmetic queue model
module tb_ak_pipe_addsub;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    int vec = 0;
    int errs = 0;
    int delivered = 0;
    logic [17:0] exp_q[$];
    logic        stall_p = 1'b0;
    logic [17:0] held = '0;

    always #5 clk = ~clk;

    ak_pipe_addsub #(.WIDTH(16), .SEG(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .cin(cin),
        .sub(sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum(sum),
        .cout(cout),
        .ovf(ovf)
    );

    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic c, input logic s);
        int   r, rs;
        logic co, ov;
        r  = s ? int'(x) - int'(y) - int'(c) : int'(x) + int'(y) + int'(c);
        rs = s ? int'($signed(x)) - int'($signed(y)) - int'(c)
               : int'($signed(x)) + int'($signed(y)) + int'(c);
        co = s ? (r >= 0) : (r > 65535);
        ov = (rs > 32767) || (rs < -32768);
        return {r[15:0], co, ov};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare process: every cycle, check handshake, stall stability and the head of the expected queue.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("in_ready_in_reset", {31'd0, in_ready}, 32'd0);
            exp_q.delete();
            stall_p = 1'b0;
        end else begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, !(out_valid && !out_ready)});
            if (stall_p) begin
                chk("stall_valid", {31'd0, out_valid}, 32'd1);
                chk("stall_hold", {14'd0, sum, cout, ovf}, {14'd0, held});
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    vec++;
                    errs++;
                    $display("FAIL spurious_out: out_valid=1 sum=%h with no result pending (t=%0t)", sum, $time);
                end else begin
                    chk("result", {14'd0, sum, cout, ovf}, {14'd0, exp_q[0]});
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        delivered++;
                    end
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
            stall_p = out_valid && !out_ready;
            held = {sum, cout, ovf};
        end
    end

    task automatic single(input logic [15:0] x, input logic [15:0] y, input logic c, input logic s,
                          input logic [17:0] lit);
        int lat = 0;
        chk("model_pin", {14'd0, model(x, y, c, s)}, {14'd0, lit});
        a = x;
        b = y;
        cin = c;
        sub = s;
        out_ready = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("latency", lat, 3);
        chk("direct", {14'd0, sum, cout, ovf}, {14'd0, lit});
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int cyc, i, d0, seen, t;
        logic acc;
        logic [15:0] edge_vals [4];
        edge_vals[0] = 16'hFFFF;
        edge_vals[1] = 16'h8000;
        edge_vals[2] = 16'h7FFF;
        edge_vals[3] = 16'h0000;

        out_ready = 1'b1;
        repeat (2) tick();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sum", {16'd0, sum}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        rst_n = 1'b1;
        tick();

        single(16'h1234, 16'h0FFF, 1'b0, 1'b0, {16'h2233, 1'b0, 1'b0});
        single(16'hFFFF, 16'h0001, 1'b1, 1'b0, {16'h0001, 1'b1, 1'b0});
        single(16'h7FFF, 16'h0001, 1'b0, 1'b0, {16'h8000, 1'b0, 1'b1});
        single(16'h0005, 16'h0007, 1'b0, 1'b1, {16'hFFFE, 1'b0, 1'b0});
        single(16'h8000, 16'h0001, 1'b0, 1'b1, {16'h7FFF, 1'b1, 1'b1});

        cyc = 0;
        i = 0;
        d0 = delivered;
        while (i < 8 && cyc < 100) begin
            a = 16'(i);
            b = 16'h0100;
            cin = 1'b0;
            sub = 1'b0;
            in_valid = 1'b1;
            out_ready = !(cyc >= 6 && cyc <= 9);
            @(negedge clk);
            acc = in_ready;
            tick();
            cyc++;
            if (acc) i++;
        end
        in_valid = 1'b0;
        while (exp_q.size() > 0 && cyc < 100) begin
            out_ready = !(cyc >= 6 && cyc <= 9);
            tick();
            cyc++;
        end
        out_ready = 1'b1;
        chk("burst_count", delivered - d0, 8);
        chk("burst_cycles", cyc, 16);

        for (int j = 0; j < 3; j++) begin
            a = 16'(j + 16'h0010);
            b = 16'h0003;
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_sum", {16'd0, sum}, 32'd0);
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            tick();
            seen += int'(out_valid);
        end
        chk("discarded", seen, 0);
        single(16'h0001, 16'h0001, 1'b0, 1'b0, {16'h0002, 1'b0, 1'b0});

        repeat (400) begin
            in_valid = $urandom_range(0, 3) != 0;
            a = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : 16'($urandom);
            b = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : 16'($urandom);
            cin = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
            out_ready = $urandom_range(0, 3) != 0;
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        t = 0;
        while (exp_q.size() > 0 && t < 50) begin
            tick();
            t++;
        end
        chk("drain", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule

// File: doc/ak_pipe_addsub.md
Name: ak_pipe_addsub

Overview:
Parametrised, pipelined add/subtract unit. Next generation of the team's fixed-width ripple-carry adder. Operand width is split into SEG-bit slices, with one slice resolved per pipeline stage, so carry ripple per cycle is bounded. Valid/ready handshake on both sides, with backpressure, so the unit drops into the datapath between a producer and a consumer.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of SEG.
SEG, 4, bits resolved per pipeline stage; STAGES = WIDTH/SEG (must be at least 1).

Ports:
clk  in  1  single clock, all logic on rising edge
rst_n  in  1  synchronous, active-low reset
in_valid  in  1  operand bundle valid
in_ready  out  1  unit can accept bundle this cycle
a  in  WIDTH  operand A
b  in  WIDTH  operand B
cin  in  1  carry-in (add) / borrow-in (sub)
sub  in  1  0 = add, 1 = subtract
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
sum  out  WIDTH  result
cout  out  1  carry-out; in sub mode 1 = no borrow
ovf  out  1  two's-complement signed overflow

Behaviour:
- Reset: synchronous, active-low, sampled on clk rising edge. While rst_n = 0, every stage valid clears, all pipeline data registers clear to 0, out_valid = 0, sum = 0, cout = 0, ovf = 0.
- in_ready is forced to 0 during reset. Deassertion takes effect on the next edge.
- Arithmetic, add (sub = 0): {cout, sum} = a + b + cin.
- Arithmetic, sub (sub = 1): {cout, sum} = a + ~b + ~cin, i.e. a - b - cin. cout = 0 signals a borrow.
- ovf = carry into MSB XOR carry out of MSB, computed on the effective operands (b inverted in sub mode).
- Pipeline: STAGES register stages.
  - Stage k (0-based) adds slice k of a and b with the carry from stage k-1. For k = 0 the carry is the effective carry-in.
  - Already-resolved sum slices and not-yet-used operand slices travel forward with the bundle.
- Latency: a bundle accepted on edge N appears with out_valid = 1 after edge N+STAGES-1 and is visible from that cycle. With WIDTH = 16, SEG = 4 the first result is visible 3 cycles after acceptance; sum/cout/ovf are registered.
- Handshake:
  - Transfer in occurs when in_valid and in_ready are both high.
  - Transfer out occurs when out_valid and out_ready are both high.
  - Global advance enable: en = !out_valid || out_ready. When en = 0 the whole pipeline holds, bubbles included (no bubble collapse).
  - in_ready = en, and is combinationally dependent on out_ready.
- Bubbles: in_valid = 0 with en = 1 inserts an invalid slot. Outputs hold their last value, with out_valid = 0.
- While out_valid = 1 and out_ready = 0: sum, cout and ovf stay stable until the transfer completes.
- Throughput: one result per cycle when out_ready is held high.
- Ordering: results are delivered strictly in acceptance order; no drops, no duplicates.
- Simultaneous accept and deliver in one cycle is legal and required at full rate.
- Wrap-around: modulo 2^WIDTH; the carry/borrow appears only on cout.
- Reset mid-operation: all in-flight bundles are discarded, with no partial result ever presented.
- STAGES = 1: the unit degenerates to a registered full-width adder with the same handshake.

Decomposition:
- Shared package/include ak_add_pkg holds:
  - the mode encoding (ADD = 0, SUB = 1);
  - the STAGES derivation;
  - an elaboration-time check that WIDTH % SEG == 0.
- One natural sub-module: ak_slice_add. It is a combinational SEG-bit ripple-carry slice built from the team's 1-bit full-adder cell and exports the carry into and out of its MSB (for ovf). It is instantiated STAGES times via generate.
- Pipeline registers and handshake stay in ak_pipe_addsub.

Test Plan:
All scenarios use WIDTH = 16, SEG = 4.
- Add, cin = 0: a = 0x1234, b = 0x0FFF -> sum 0x2233, cout 0, ovf 0, out_valid 3 cycles after acceptance.
- Add with carry: a = 0xFFFF, b = 0x0001, cin = 1 -> sum 0x0001, cout 1, ovf 0.
- Signed overflow on add: a = 0x7FFF, b = 0x0001, cin = 0 -> sum 0x8000, cout 0, ovf 1.
- Sub:
  - a = 0x0005, b = 0x0007, cin = 0 -> sum 0xFFFE, cout 0, ovf 0.
  - a = 0x8000, b = 0x0001, cin = 0 -> sum 0x7FFF, cout 1, ovf 1.
- Backpressure: 8 back-to-back bundles (a = i, b = 0x0100, i = 0..7), out_ready low for cycles 6-9.
  - in_ready low exactly while out_valid && !out_ready.
  - Outputs are held stable while stalled.
  - Exactly 8 results 0x0100..0x0107 in order, with 1/cycle restored afterwards.
- Reset mid-stream: 3 bundles in flight, rst_n = 0 for 1 cycle -> next cycle out_valid 0 and sum 0. No result from the discarded bundles ever appears. A fresh 0x0001 + 0x0001 then returns 0x0002 after 3 cycles.
